// File: rtl/bp_resolver_pkg.sv
// Shared constants for the branch-prediction resolver: direction encodings,
// FSM state encodings and the width of a queued prediction entry.
package bp_resolver_pkg;

    localparam logic TAKEN     = 1'b1;
    localparam logic NOT_TAKEN = 1'b0;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    // A queued entry is {idx, taken}, with the predicted direction in bit 0.
    function automatic int entry_w(input int idx_w);
        return idx_w + 1;
    endfunction

endpackage

// File: rtl/bp_fifo.sv
// In-order queue of in-flight predictions. Clear beats push and pop so a
// wrong-path fetch in the flush cycle never lands in the queue.
module bp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_clear,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  logic [W-1:0]                   i_wdata,
    output logic [W-1:0]                   o_rdata,
    output logic [$clog2(DEPTH+1)-1:0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [DEPTH-1:0][W-1:0] r_mem;
    logic [AW-1:0]           r_wr;
    logic [AW-1:0]           r_rd;
    logic [CW-1:0]           r_cnt;
    logic                    w_do_push;
    logic                    w_do_pop;

    assign w_do_push = i_push && (r_cnt != FULL_C) && !i_clear;
    assign w_do_pop  = i_pop && (r_cnt != '0) && !i_clear;

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_reset)
            r_mem[r_wr] <= i_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd];
    assign o_count = r_cnt;

endmodule

// File: rtl/bp_resolver.sv
// Resolves queued fetch-time predictions in order against execute outcomes,
// trains the predictor, pulses mispredict/flush and keeps saturating stats.
module bp_resolver
    import bp_resolver_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_pred_valid,
    input  logic                         i_pred_taken,
    input  logic [IDX_W-1:0]             i_pred_idx,
    output logic                         o_pred_ready,
    input  logic                         i_res_valid,
    input  logic                         i_res_taken,
    output logic                         o_res_ready,
    output logic                         o_upd_valid,
    output logic [IDX_W-1:0]             o_upd_idx,
    output logic                         o_upd_taken,
    output logic                         o_mispredict,
    output logic [$clog2(DEPTH+1)-1:0]   o_inflight,
    output logic [CNT_W-1:0]             o_br_count,
    output logic [CNT_W-1:0]             o_miss_count
);
    localparam int EW = entry_w(IDX_W);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [0:0]       r_state;
    logic             r_upd_valid;
    logic [IDX_W-1:0] r_upd_idx;
    logic             r_upd_taken;
    logic             r_mispredict;
    logic [CNT_W-1:0] r_br_count;
    logic [CNT_W-1:0] r_miss_count;

    logic [EW-1:0]    w_head;
    logic [CW-1:0]    w_count;
    logic             w_pred_ready;
    logic             w_res_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_miss;

    // Readiness looks at current occupancy only; a same-cycle pop frees nothing.
    assign w_pred_ready = (r_state == ST_RUN) && (w_count != FULL_C);
    assign w_res_ready  = (r_state == ST_RUN) && (w_count != '0);
    assign w_push       = i_pred_valid && w_pred_ready;
    assign w_pop        = i_res_valid && w_res_ready;
    assign w_miss       = w_pop && (i_res_taken != w_head[0]);

    bp_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_miss),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({i_pred_idx, i_pred_taken}),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_RUN;
            r_upd_valid  <= 1'b0;
            r_upd_idx    <= '0;
            r_upd_taken  <= NOT_TAKEN;
            r_mispredict <= 1'b0;
            r_br_count   <= '0;
            r_miss_count <= '0;
        end else begin
            r_state      <= w_miss ? ST_FLUSH : ST_RUN;
            r_upd_valid  <= w_pop;
            r_mispredict <= w_miss;
            if (w_pop) begin
                r_upd_idx   <= w_head[EW-1:1];
                r_upd_taken <= i_res_taken;
                if (r_br_count != '1)
                    r_br_count <= r_br_count + 1'b1;
            end
            if (w_miss && (r_miss_count != '1))
                r_miss_count <= r_miss_count + 1'b1;
        end
    end

    assign o_pred_ready = w_pred_ready;
    assign o_res_ready  = w_res_ready;
    assign o_upd_valid  = r_upd_valid;
    assign o_upd_idx    = r_upd_idx;
    assign o_upd_taken  = r_upd_taken;
    assign o_mispredict = r_mispredict;
    assign o_inflight   = w_count;
    assign o_br_count   = r_br_count;
    assign o_miss_count = r_miss_count;

endmodule

// File: tb/tb_bp_resolver.sv
// Bench for bp_resolver: vector table with hand-derived occupancy/pulse
// expectations plus a training scoreboard; a CNT_W=2 copy shares the stimulus.
module tb_bp_resolver;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_pred_valid, i_pred_taken, i_res_valid, i_res_taken;
    logic [3:0] i_pred_idx;

    logic       a_pred_ready, a_res_ready, a_upd_valid, a_upd_taken, a_mispredict;
    logic [3:0] a_upd_idx;
    logic [2:0] a_inflight;
    logic [15:0] a_br, a_miss;

    logic       b_pred_ready, b_res_ready, b_upd_valid, b_upd_taken, b_mispredict;
    logic [3:0] b_upd_idx;
    logic [2:0] b_inflight;
    logic [1:0] b_br, b_miss;

    always #5 i_clk = ~i_clk;

    bp_resolver #(.DEPTH(4), .IDX_W(4), .CNT_W(16)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_pred_valid(i_pred_valid), .i_pred_taken(i_pred_taken), .i_pred_idx(i_pred_idx),
        .o_pred_ready(a_pred_ready),
        .i_res_valid(i_res_valid), .i_res_taken(i_res_taken), .o_res_ready(a_res_ready),
        .o_upd_valid(a_upd_valid), .o_upd_idx(a_upd_idx), .o_upd_taken(a_upd_taken),
        .o_mispredict(a_mispredict), .o_inflight(a_inflight),
        .o_br_count(a_br), .o_miss_count(a_miss)
    );

    bp_resolver #(.DEPTH(4), .IDX_W(4), .CNT_W(2)) dut_sat (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_pred_valid(i_pred_valid), .i_pred_taken(i_pred_taken), .i_pred_idx(i_pred_idx),
        .o_pred_ready(b_pred_ready),
        .i_res_valid(i_res_valid), .i_res_taken(i_res_taken), .o_res_ready(b_res_ready),
        .o_upd_valid(b_upd_valid), .o_upd_idx(b_upd_idx), .o_upd_taken(b_upd_taken),
        .o_mispredict(b_mispredict), .o_inflight(b_inflight),
        .o_br_count(b_br), .o_miss_count(b_miss)
    );

    typedef struct {
        logic       pv, pt;
        logic [3:0] pidx;
        logic       rv, rt;
        int         infl;
        logic       misp, updv;
    } vec_t;

    typedef struct {
        logic [3:0] idx;
        logic       t;
    } ent_t;

    vec_t tbl[$];
    ent_t mq[$];
    ent_t sb[$];
    logic m_flush;
    int   m_br, m_miss;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic pv, input logic pt, input int pidx,
                                input logic rv, input logic rt,
                                input int infl, input logic misp, input logic updv);
        vec_t v;
        v.pv = pv; v.pt = pt; v.pidx = pidx[3:0]; v.rv = rv; v.rt = rt;
        v.infl = infl; v.misp = misp; v.updv = updv;
        return v;
    endfunction

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic model_reset();
        mq.delete(); sb.delete();
        m_flush = 1'b0; m_br = 0; m_miss = 0;
    endtask

    // One cycle: drive, check handshakes, advance model, check registered outputs.
    task automatic apply(input vec_t v);
        logic pr, rr, push, pop, miss;
        ent_t h, e;
        i_pred_valid = v.pv; i_pred_taken = v.pt; i_pred_idx = v.pidx;
        i_res_valid  = v.rv; i_res_taken  = v.rt;
        pr = !m_flush && (mq.size() < 4);
        rr = !m_flush && (mq.size() > 0);
        chk("pred_ready", int'(a_pred_ready), int'(pr));
        chk("res_ready", int'(a_res_ready), int'(rr));
        push = v.pv && pr;
        pop  = v.rv && rr;
        miss = 1'b0;
        if (pop) begin
            h = mq.pop_front();
            e.idx = h.idx; e.t = v.rt;
            sb.push_back(e);
            m_br++;
            miss = (v.rt != h.t);
        end
        if (miss) begin
            mq.delete(); m_miss++; m_flush = 1'b1;
        end else begin
            m_flush = 1'b0;
            if (push) begin
                e.idx = v.pidx; e.t = v.pt;
                mq.push_back(e);
            end
        end
        @(posedge i_clk); #1;
        chk("inflight_tbl", int'(a_inflight), v.infl);
        chk("inflight_model", int'(a_inflight), mq.size());
        chk("mispredict", int'(a_mispredict), int'(v.misp));
        chk("upd_valid", int'(a_upd_valid), int'(v.updv));
        if (a_upd_valid) begin
            if (sb.size() == 0) chk("sb_unexpected_upd", 1, 0);
            else begin
                e = sb.pop_front();
                chk("upd_idx", int'(a_upd_idx), int'(e.idx));
                chk("upd_taken", int'(a_upd_taken), int'(e.t));
            end
        end
        chk("sb_pending", sb.size(), 0);
        chk("br_count", int'(a_br), m_br);
        chk("miss_count", int'(a_miss), m_miss);
        chk("sat_br", int'(b_br), sat3(m_br));
        chk("sat_miss", int'(b_miss), sat3(m_miss));
        chk("sat_mispredict", int'(b_mispredict), int'(v.misp));
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_pred_valid = 0; i_pred_taken = 0; i_pred_idx = 0; i_res_valid = 0; i_res_taken = 0;
        repeat (2) @(posedge i_clk);
        #1;
        model_reset();
        chk("rst_pred_ready", int'(a_pred_ready), 1);
        chk("rst_res_ready", int'(a_res_ready), 0);
        chk("rst_inflight", int'(a_inflight), 0);
        chk("rst_upd_valid", int'(a_upd_valid), 0);
        chk("rst_mispredict", int'(a_mispredict), 0);
        chk("rst_br", int'(a_br), 0);
        chk("rst_miss", int'(a_miss), 0);
        chk("rst_sat_br", int'(b_br), 0);
        i_reset = 1'b0;
    endtask

    initial begin
        // pv pt idx rv rt | inflight mispredict upd_valid
        tbl.push_back(mk(1, 1, 3, 0, 0, 1, 0, 0));  // push idx3 taken
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1));  // correct resolve
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));  // resolve while empty ignored
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 2, 0, 0, 2, 0, 0));
        tbl.push_back(mk(1, 1, 3, 0, 0, 3, 0, 0));
        tbl.push_back(mk(1, 1, 4, 0, 0, 4, 0, 0));  // full
        tbl.push_back(mk(1, 1, 5, 1, 1, 3, 0, 1));  // push refused, pop correct
        tbl.push_back(mk(1, 1, 6, 1, 1, 0, 1, 1));  // head t=0 -> mispredict, push dropped
        tbl.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0));  // flush cycle: push refused
        tbl.push_back(mk(1, 0, 7, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 8, 1, 0, 1, 0, 1));  // push+pop same cycle
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1));  // head idx8 t=1 resolved 0
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(mk(1, 0, 9 + k, 0, 0, 1, 0, 0));
            tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1));
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        end

        do_reset();
        foreach (tbl[i]) apply(tbl[i]);
        chk("final_miss", int'(a_miss), 5);
        chk("final_sat_miss", int'(b_miss), 3);
        chk("final_sat_br", int'(b_br), 3);

        // Reset with entries in flight: no training or flush pulse for them.
        apply(mk(1, 1, 12, 0, 0, 1, 0, 0));
        apply(mk(1, 0, 13, 0, 0, 2, 0, 0));
        do_reset();
        apply(mk(0, 0, 0, 1, 0, 0, 0, 0));
        apply(mk(1, 0, 14, 0, 0, 1, 0, 0));
        apply(mk(0, 0, 0, 1, 0, 0, 0, 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
